// File: rtl/muldiv_seq.sv
// Iterative MULT/DIV sequencer owning HI/LO; stalls the pipe while busy.
// Optional MULDIV_SEQ_EARLY_OUT_EN: zero-multiplier and divide-by-zero early exit.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_MD_start,
  input  logic [2:0]       i_MD_op,
  input  logic [WIDTH-1:0] i_MD_a,
  input  logic [WIDTH-1:0] i_MD_b,
  input  logic             i_MD_flush,
  input  logic             i_MD_read,
  output logic             o_MD_busy,
  output logic             o_MD_stall,
  output logic             o_MD_done,
  output logic [WIDTH-1:0] o_MD_hi,
  output logic [WIDTH-1:0] o_MD_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sgn_op;
  logic               md_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_trial;
  logic [2*WIDTH-1:0] m_next;
  logic [2*WIDTH-1:0] d_next;

  assign sgn_op = ~i_MD_op[0];
  assign md_op  = ~i_MD_op[2];
  assign a_neg  = sgn_op & i_MD_a[WIDTH-1];
  assign b_neg  = sgn_op & i_MD_b[WIDTH-1];
  assign a_mag  = a_neg ? -i_MD_a : i_MD_a;
  assign b_mag  = b_neg ? -i_MD_b : i_MD_b;
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign quo    = acc[WIDTH-1:0];

  // upper half is partial product (mul) or remainder (div)
  always_comb begin
    m_sum   = {1'b0, rem} + (acc[0] ? {1'b0, opd} : '0);
    m_next  = {m_sum, acc[WIDTH-1:1]};
    d_trial = {rem, acc[WIDTH-1]} - {1'b0, opd};
    d_next  = d_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {d_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

`ifdef MULDIV_SEQ_EARLY_OUT_EN
  logic [WIDTH-1:0] mask;
  assign mask = (WIDTH'(1) << cnt) - WIDTH'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (i_MD_flush) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_MD_start && !done_q) begin
            unique case (1'b1)
              md_op: begin
                is_div <= i_MD_op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= i_MD_op[1] & (i_MD_b == '0);
                opd    <= i_MD_op[1] ? b_mag : a_mag;
                acc    <= {{WIDTH{1'b0}}, (i_MD_op[1] ? a_mag : b_mag)};
                cnt    <= CNT_TOP;
                state  <= CALC;
`ifdef MULDIV_SEQ_EARLY_OUT_EN
                if (i_MD_b == '0) begin
                  acc   <= {(i_MD_op[1] ? a_mag : '0), {WIDTH{1'b0}}};
                  state <= FIX;
                end
`endif
              end
              (i_MD_op == 3'd4): hi_q <= i_MD_a;
              (i_MD_op == 3'd5): lo_q <= i_MD_a;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= is_div ? d_next : m_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
`ifdef MULDIV_SEQ_EARLY_OUT_EN
          // remaining iterations would only shift; do them at once
          if (!is_div && cnt != '0 && (m_next[WIDTH-1:0] & mask) == '0) begin
            acc   <= m_next >> cnt;
            state <= FIX;
          end
`endif
        end
        FIX: begin
          if (is_div) begin
            lo_q <= dz ? '1 : (neg_q ? -quo : quo);
            hi_q <= neg_r ? -rem : rem;
          end else begin
            {hi_q, lo_q} <= neg_q ? -acc : acc;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_MD_busy  = (state != IDLE);
  assign o_MD_stall = o_MD_busy & (i_MD_start | i_MD_read);
  assign o_MD_done  = done_q;
  assign o_MD_hi    = hi_q;
  assign o_MD_lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq against a plain-arithmetic HI/LO model.
// Also covers flush, stall, ignored starts and async reset.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        rd = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_MD_start (start),
    .i_MD_op    (op),
    .i_MD_a     (a),
    .i_MD_b     (b),
    .i_MD_flush (flush),
    .i_MD_read  (rd),
    .o_MD_busy  (busy),
    .o_MD_stall (stall),
    .o_MD_done  (done),
    .o_MD_hi    (hi),
    .o_MD_lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // {HI,LO} after an op, from the architectural definition
  function automatic logic [63:0] ref_md(input logic [2:0] o,
                                         input logic [31:0] x, y, h, l);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: p = 64'(sx * sy);
      3'd1: p = {32'd0, x} * {32'd0, y};
      3'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF}
                         : {32'(sx % sy), 32'(sx / sy)};
      3'd3: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd4: p = {x, l};
      3'd5: p = {h, x};
      default: p = {h, l};
    endcase
    return p;
  endfunction

  task automatic issue_run(input logic [2:0] o, input logic [31:0] x, y,
                           output int cyc, output int dn);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) dn++;
      if (!busy) break;
      cyc++;
      @(negedge clk);
    end
    if (busy) chk("timeout", 64'd1, 64'd0);
    @(negedge clk);
    if (done) dn++;
  endtask

  task automatic do_op(input string tag, input logic [2:0] o,
                       input logic [31:0] x, y);
    int cyc, dn;
    issue_run(o, x, y, cyc, dn);
    {mhi, mlo} = ref_md(o, x, y, mhi, mlo);
    chk({tag, "_cyc"}, 64'(cyc), (o < 3'd4) ? 64'd33 : 64'd0);
    chk({tag, "_done"}, 64'(dn), (o < 3'd4) ? 64'd1 : 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(mhi));
    chk({tag, "_lo"}, 64'(lo), 64'(mlo));
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    do_op("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_hi_k", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo_k", 64'(lo), 64'hFFFF_FFEB);
    do_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    chk("divu_lo_k", 64'(lo), 64'd14);
    chk("divu_hi_k", 64'(hi), 64'd2);
    do_op("div_m100_7", 3'd2, -32'sd100, 32'd7);
    chk("div_lo_k", 64'(lo), 64'hFFFF_FFF2);
    chk("div_hi_k", 64'(hi), 64'hFFFF_FFFE);
    do_op("div_by0", 3'd2, 32'h1234_5678, 32'd0);
    do_op("divu_by0", 3'd3, 32'h8765_4321, 32'd0);
    do_op("div_by0_neg", 3'd2, 32'hF000_0001, 32'd0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("nop6", 3'd6, 32'h1111_1111, 32'd3);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd1 + 32'($urandom_range(0, 9));
      do_op("rand", ro, ra, rb);
    end

    // flush coincident with an MTLO in IDLE discards it
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_lo", 64'(lo), 64'(mlo));

    // flush mid-loop keeps HI/LO and gives no done
    do_op("mthi", 3'd4, 32'hAAAA_0000, 32'd0);
    do_op("mtlo", 3'd5, 32'h0000_5555, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = '1; b = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hi", 64'(hi), 64'hAAAA_0000);
    chk("flush_lo", 64'(lo), 64'h0000_5555);
    @(negedge clk);
    chk("flush_done2", 64'(done), 64'd0);
    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi_k", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo_k", 64'(lo), 64'h0000_0001);

    // MFHI/MFLO stall while busy
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = -32'sd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; rd = 1'b1;
    for (int i = 0; i < 35; i++) begin
      #1;
      chk("stall_rd", 64'(stall), 64'(i < 33));
      chk("done_rd", 64'(done), 64'(i == 33));
      @(negedge clk);
    end
    rd = 1'b0;
    {mhi, mlo} = ref_md(3'd2, -32'sd100, 32'd7, mhi, mlo);
    chk("rd_hi", 64'(hi), 64'(mhi));
    chk("rd_lo", 64'(lo), 64'(mlo));

    // second start mid-loop is stalled and not accepted
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    #1;
    chk("busy_start_stall", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("ign_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("ign_busy", 64'(busy), 64'd0);
    {mhi, mlo} = ref_md(3'd3, 32'd100, 32'd7, mhi, mlo);
    chk("ign_hi", 64'(hi), 64'(mhi));
    chk("ign_lo", 64'(lo), 64'(mlo));

    // start during the done cycle waits one cycle
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("dc_done", 64'(done), 64'd1);
    {mhi, mlo} = ref_md(3'd3, 32'd1000, 32'd3, mhi, mlo);
    start = 1'b1; op = 3'd5; a = 32'h77;
    @(negedge clk);
    chk("dc_lo_hold", 64'(lo), 64'(mlo));
    chk("dc_hi", 64'(hi), 64'(mhi));
    @(negedge clk);
    start = 1'b0;
    mlo = 32'h77;
    chk("dc_lo_next", 64'(lo), 64'(mlo));

    // async reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    #1 rst = 1'b0;
    mhi = '0;
    mlo = '0;
    do_op("arst_mtlo", 3'd5, 32'd5, 32'd0);
    do_op("post_mult", 3'd1, 32'd123, 32'd456);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer sitting beside the EXE stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE, runs a radix-2 shift-add or restoring-divide loop over multiple cycles, and owns the HI/LO registers.
- Drives a busy/stall signal the hazard logic uses to freeze IF/ID/EXE while a long operation is in flight, or when a MFHI/MFLO would read stale HI/LO.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_MD_start  in  1  issue strobe, valid for one cycle
- i_MD_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7=no-op
- i_MD_a  in  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data
- i_MD_b  in  WIDTH  rt operand: multiplier / divisor
- i_MD_flush  in  1  abort in-flight op (branch clr from EXE)
- i_MD_read  in  1  EXE holds MFHI/MFLO this cycle
- o_MD_busy  out  1  loop active (CALC or FIX)
- o_MD_stall  out  1  busy AND (i_MD_start OR i_MD_read), combinational
- o_MD_done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
- o_MD_hi  out  WIDTH  HI register
- o_MD_lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, HI=0, LO=0, counter=0, busy=0, done=0, all internal shift registers 0. Reset mid-operation aborts immediately; HI/LO return to 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start with op 0-3 latches operand magnitudes (signed ops: two's-complement absolute value), sign flags (quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB], product sign = a[MSB]^b[MSB]), counter=WIDTH-1 -> CALC.
  - op 4/5: HI or LO <= i_MD_a on that edge; stays IDLE; busy never asserted.
  - op 6/7: ignored.
- CALC, one iteration per cycle; counter decrements; at counter==0 -> FIX.
  - Multiply: if multiplier LSB, add multiplicand into upper half of a 2*WIDTH accumulator, shift right 1.
  - Divide: shift remainder/quotient left 1, trial-subtract divisor, keep if non-negative and set quotient bit.
- FIX (1 cycle): apply sign correction; write HI/LO; done=1 for this cycle; -> IDLE.
  - Multiply: {HI,LO} = 2*WIDTH product.
  - Divide: LO=quotient, HI=remainder.
- Latency: start at edge N -> HI/LO updated and done high after edge N+WIDTH+1; busy high for WIDTH+1 cycles.
- Divide by zero (b==0, DIV/DIVU): loop still runs; result LO=all ones, HI=i_MD_a (unsigned dividend for DIVU, original signed value for DIV); no exception.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored (op not accepted); o_MD_stall=1 so EXE holds the instruction until IDLE. A start on the done cycle is not accepted; it is accepted the following cycle.
- MTHI/MTLO while busy: stalled like any start; applied only once IDLE.
- flush: highest priority after reset; in CALC/FIX -> IDLE next edge, HI/LO unchanged, no done pulse. Flush coincident with start in IDLE: start discarded.
- i_MD_read with busy=0: no stall; HI/LO read directly (new value is visible the cycle after done).

Optional Feature:
- Macro MULDIV_SEQ_EARLY_OUT_EN.
- Defined:
  - Multiply in CALC jumps to FIX as soon as the remaining multiplier bits are all zero, with the accumulator aligned by the remaining shift count. Latency becomes variable: 2 cycles minimum for b==0.
  - Divide by zero goes IDLE -> FIX directly (2-cycle latency).
- Undefined: fixed WIDTH+1 busy cycles for every MULT/DIV op, as above.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, single done pulse.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=-100, b=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- DIV by zero a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678. With MULTU b=0, EARLY_OUT_EN: busy for exactly 1 cycle.
- Start MULTU 0xFFFFFFFF*0xFFFFFFFF, flush at cycle 10:
  - Next cycle: IDLE, no done, HI/LO hold prior MTHI/MTLO values 0xAAAA0000/0x5555.
  - Then MULTU result HI=0xFFFFFFFE, LO=0x00000001.
- During busy:
  - Assert i_MD_read -> o_MD_stall=1 each cycle until done, then 0.
  - Second start mid-loop -> ignored, first result intact.
- Async rst pulse mid-CALC (not clock-aligned) -> busy=0, HI=LO=0 immediately; next MTLO 0x5 -> LO=5 after one edge.
